// File: rtl/split_adder_pipe_pkg.sv
// Shared constants for the split 32-bit adder pipeline.
// The datapath width and per-stage carry-chain width are defined here only.
package split_adder_pipe_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int DATA_HALF  = DATA_WIDTH / 2;

endpackage

// File: rtl/split_adder_pipe_add_half_stage.sv
// Registered N-bit adder used as one pipeline stage of split_adder_pipe.
// Sum and carry-out load together on 'load'; synchronous active-low reset clears both.
module add_half_stage
    import split_adder_pipe_pkg::*;
#(
    parameter int N = DATA_HALF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] sum,
    output logic         co
);

    logic [N:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum <= '0;
            co  <= 1'b0;
        end else if (load) begin
            sum <= total[N-1:0];
            co  <= total[N];
        end
    end

endmodule

// File: rtl/split_adder_pipe.sv
// Two-stage WIDTH-bit adder: low half in stage 1, high half plus the registered
// low carry in stage 2, with valid/ready handshakes and full backpressure.
module split_adder_pipe
    import split_adder_pipe_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int HALF  = WIDTH / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);

    logic            s1_valid;
    logic            s2_valid;
    logic            s1_can_load;
    logic            s2_can_load;
    logic            in_xfer;
    logic            s2_load;
    logic            out_xfer;

    logic [HALF-1:0] lo_sum;
    logic            lo_carry;
    logic [HALF-1:0] a_hi_q;
    logic [HALF-1:0] b_hi_q;

    logic [HALF-1:0] hi_sum;
    logic            cout_q;
    logic [HALF-1:0] lo_sum_q2;
    logic            a_sign_q;
    logic            b_sign_q;

    assign s2_can_load = !s2_valid || out_ready;
    assign s1_can_load = !s1_valid || s2_can_load;
    assign in_ready    = s1_can_load;
    assign in_xfer     = in_valid && in_ready;
    assign s2_load     = s1_valid && s2_can_load;
    assign out_xfer    = s2_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
        end else if (out_xfer) begin
            s2_valid <= 1'b0;
        end
    end

    add_half_stage #(.N(HALF)) u_lo_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (in_xfer),
        .a     (input1[HALF-1:0]),
        .b     (input2[HALF-1:0]),
        .ci    (cin),
        .sum   (lo_sum),
        .co    (lo_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_hi_q <= '0;
            b_hi_q <= '0;
        end else if (in_xfer) begin
            a_hi_q <= input1[WIDTH-1:HALF];
            b_hi_q <= input2[WIDTH-1:HALF];
        end
    end

    add_half_stage #(.N(HALF)) u_hi_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (s2_load),
        .a     (a_hi_q),
        .b     (b_hi_q),
        .ci    (lo_carry),
        .sum   (hi_sum),
        .co    (cout_q)
    );

    // Low half and operand signs travel alongside so stage 1 can accept new work.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lo_sum_q2 <= '0;
            a_sign_q  <= 1'b0;
            b_sign_q  <= 1'b0;
        end else if (s2_load) begin
            lo_sum_q2 <= lo_sum;
            a_sign_q  <= a_hi_q[HALF-1];
            b_sign_q  <= b_hi_q[HALF-1];
        end
    end

    assign out_valid = s2_valid;
    assign out       = {hi_sum, lo_sum_q2};
    assign cout      = cout_q;
    assign ovf       = (a_sign_q == b_sign_q) && (hi_sum[HALF-1] != a_sign_q);

endmodule

// File: tb/tb_split_adder_pipe.sv
// Scoreboard bench for split_adder_pipe: driver pushes reference results on each
// accepted input, an independent monitor pops and compares on each output transfer.
module tb_split_adder_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] input1;
    logic [31:0] input2;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        cout;
    logic        ovf;

    typedef struct {
        logic [31:0] sum;
        logic        c;
        logic        v;
    } exp_t;

    exp_t exp_q[$];
    int   out_cycles[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   stale_cnt = 0;
    int   acc_cycle = 0;
    bit   stop_toggle = 0;

    split_adder_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .input1    (input1),
        .input2    (input2),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t ref_add(input logic [31:0] a, input logic [31:0] b, input logic c);
        exp_t        e;
        longint      s_signed;
        longint      s_unsigned;
        s_unsigned = longint'({32'd0, a}) + longint'({32'd0, b}) + longint'(c);
        s_signed   = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
        e.sum = s_unsigned[31:0];
        e.c   = (s_unsigned >= 64'sh1_0000_0000);
        e.v   = (s_signed > 64'sd2147483647) || (s_signed < -64'sd2147483648);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Monitor: compare every output transfer against the oldest outstanding reference.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                stale_cnt++;
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sum", {32'd0, out}, {32'd0, e.sum});
                chk("cout", {63'd0, cout}, {63'd0, e.c});
                chk("ovf", {63'd0, ovf}, {63'd0, e.v});
                out_cycles.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c);
        int waited;
        bit done;
        waited = 0;
        done   = 0;
        in_valid = 1'b1;
        input1   = a;
        input2   = b;
        cin      = c;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(ref_add(a, b, c));
                acc_cycle = cyc;
                done = 1;
            end
            @(posedge clk);
            #1;
            if (!done) begin
                waited++;
                if (waited > 60) begin
                    chk("accept_timeout", 64'd1, 64'd0);
                    done = 1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_out"}, {32'd0, out}, 64'd0);
        chk({tag, "_cout"}, {63'd0, cout}, 64'd0);
        chk({tag, "_ovf"}, {63'd0, ovf}, 64'd0);
        chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        int first_acc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        input1    = '0;
        input2    = '0;
        cin       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_state("reset");
        @(posedge clk);
        #1;

        // Directed corner cases, one at a time, with latency check on the first.
        out_cycles.delete();
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        first_acc = acc_cycle;
        drain();
        chk("latency", 64'(out_cycles.size() > 0 ? out_cycles[0] - first_acc : -1), 64'd2);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b0);
        send(32'h0000_FFFF, 32'h0000_0001, 1'b0);
        send(32'd5, 32'd6, 1'b1);
        send(32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
        send(32'h8000_0000, 32'h8000_0000, 1'b1);
        drain();

        // Backpressure: four back-to-back ops with the consumer stalled for 5 cycles.
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 4; i++) send(32'(i), 32'(16 * i), 1'b0);
            end
            begin
                repeat (3) @(negedge clk);
                chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
                chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
                chk("bp_hold_c2", {32'd0, out}, 64'h11);
                @(negedge clk);
                chk("bp_hold_c3", {32'd0, out}, 64'h11);
                @(negedge clk);
                chk("bp_hold_c4", {32'd0, out}, 64'h11);
                chk("bp_in_ready_c4", {63'd0, in_ready}, 64'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Full throughput: 8 random pairs, results on 8 consecutive cycles.
        out_cycles.delete();
        for (int i = 0; i < 8; i++) begin
            send($urandom, $urandom, 1'($urandom_range(0, 1)));
            if (i == 0) first_acc = acc_cycle;
        end
        drain();
        chk("tput_count", 64'(out_cycles.size()), 64'd8);
        for (int i = 0; i < out_cycles.size(); i++)
            chk("tput_cycle", 64'(out_cycles[i]), 64'(first_acc + 2 + i));

        // Random in_valid gaps and random consumer stalls.
        stop_toggle = 0;
        fork
            begin
                while (!stop_toggle) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int i = 0; i < 150; i++) begin
            send($urandom, $urandom, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        stop_toggle = 1;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        // Reset with two entries in flight: they must vanish.
        out_ready = 1'b0;
        send(32'h1234_5678, 32'h1111_1111, 1'b0);
        send(32'hFFFF_0000, 32'h0001_0000, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        check_reset_state("midreset");
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("no_stale_output", 64'(stale_cnt), 64'd0);

        send(32'hDEAD_BEEF, 32'h2152_4111, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
